// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
// Bounded up/down counter over the range 0..MAX_VALUE with a variable step.
// When a step would leave the range, a one-cycle overflow/underflow pulse is
// raised and a saturating 16-bit event counter is bumped.
//
// Build option: define UPDOWN_COUNTER_SATURATE_EN to clamp at the range
// limits instead of wrapping modulo (MAX_VALUE+1). Ports are the same in
// both builds.
// ---------------------------------------------------------------------------
module param_updown_counter #(
    parameter int                WIDTH      = 32,
    parameter longint unsigned   MAX_VALUE  = (64'd1 << WIDTH) - 64'd1,
    parameter int                STEP_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  inst,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    output logic [WIDTH-1:0]      value,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  at_max,
    output logic                  at_zero,
    output logic [15:0]           wrap_count
);

    // All range arithmetic is done one bit wider than the count so that
    // value+step and value+(MAX_VALUE+1) never truncate before comparison.
    localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0]   RANGE_EXT = MAX_EXT + 1'b1;
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] r_value;
    logic             r_overflow;
    logic             r_underflow;
    logic [15:0]      r_wrap_count;

    logic [WIDTH:0]   w_val_ext;
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_load_ext;
    logic             w_up_ovf;
    logic             w_down_unf;
    logic [WIDTH-1:0] w_value_next;
    logic             w_overflow_next;
    logic             w_underflow_next;
    logic             w_event;

    assign w_val_ext  = {1'b0, r_value};
    assign w_step_ext = {{(WIDTH+1-STEP_WIDTH){1'b0}}, step};
    assign w_load_ext = {1'b0, load_value};

    // A step larger than the whole range is treated as a full-range step.
    assign w_s        = (w_step_ext > MAX_EXT) ? MAX_EXT : w_step_ext;
    assign w_sum      = w_val_ext + w_s;
    assign w_up_ovf   = (w_sum > MAX_EXT);
    assign w_down_unf = (w_val_ext < w_s);

    // Next-state selection: load beats count enable; idle holds the value.
    always_comb begin
        w_value_next     = r_value;
        w_overflow_next  = 1'b0;
        w_underflow_next = 1'b0;
        if (load) begin
            w_value_next = (w_load_ext > MAX_EXT) ? MAX_VAL : load_value;
        end else if (en) begin
            if (!inst) begin
                if (w_up_ovf) begin
                    w_overflow_next = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    w_value_next    = MAX_VAL;
`else
                    w_value_next    = WIDTH'(w_sum - RANGE_EXT);
`endif
                end else begin
                    w_value_next = WIDTH'(w_sum);
                end
            end else begin
                if (w_down_unf) begin
                    w_underflow_next = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    w_value_next     = '0;
`else
                    w_value_next     = WIDTH'(w_val_ext + RANGE_EXT - w_s);
`endif
                end else begin
                    w_value_next = WIDTH'(w_val_ext - w_s);
                end
            end
        end
    end

    assign w_event = w_overflow_next | w_underflow_next;

    // Count, flag and event-counter registers; reset has top priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_value      <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_wrap_count <= 16'd0;
        end else begin
            r_value     <= w_value_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
            if (w_event && (r_wrap_count != 16'hFFFF)) begin
                r_wrap_count <= r_wrap_count + 16'd1;
            end
        end
    end

    assign value      = r_value;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;
    assign wrap_count = r_wrap_count;
    assign at_max     = (r_value == MAX_VAL);
    assign at_zero    = (r_value == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_param_updown_counter
// Directed test of param_updown_counter (WIDTH=8, MAX_VALUE=9, STEP_WIDTH=4).
// Expected results come from a behavioural model, are queued when inputs are
// applied and compared one clock later when the DUT registers them. Works for
// both the wrap build and the UPDOWN_COUNTER_SATURATE_EN build.
// ---------------------------------------------------------------------------
module tb_param_updown_counter;

    localparam int WIDTH      = 8;
    localparam int MAXV       = 9;
    localparam int STEP_WIDTH = 4;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  en = 1'b0;
    logic                  inst = 1'b0;
    logic [STEP_WIDTH-1:0] step = '0;
    logic                  load = 1'b0;
    logic [WIDTH-1:0]      load_value = '0;
    logic [WIDTH-1:0]      value;
    logic                  overflow;
    logic                  underflow;
    logic                  at_max;
    logic                  at_zero;
    logic [15:0]           wrap_count;

    param_updown_counter #(
        .WIDTH      (WIDTH),
        .MAX_VALUE  (MAXV),
        .STEP_WIDTH (STEP_WIDTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .inst       (inst),
        .step       (step),
        .load       (load),
        .load_value (load_value),
        .value      (value),
        .overflow   (overflow),
        .underflow  (underflow),
        .at_max     (at_max),
        .at_zero    (at_zero),
        .wrap_count (wrap_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int value;
        bit ov;
        bit un;
        int wc;
    } exp_t;

    exp_t sb[$];

    int  n_assert = 0;
    int  n_fail   = 0;
    int  n_txn    = 0;
    int  m_value  = 0;
    int  m_wc     = 0;
    int  m_events = 0;
    bit  m_ov     = 1'b0;
    bit  m_un     = 1'b0;

`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic chk(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Behavioural reference: advance the model by one clock edge.
    task automatic model_step(input bit r, input bit ld, input int lv,
                              input bit e, input bit dn, input int st);
        int s;
        m_ov = 1'b0;
        m_un = 1'b0;
        if (r) begin
            m_value = 0;
            m_wc    = 0;
        end else if (ld) begin
            m_value = (lv > MAXV) ? MAXV : lv;
        end else if (e) begin
            s = (st > MAXV) ? MAXV : st;
            if (!dn) begin
                if (m_value + s > MAXV) begin
                    m_ov    = 1'b1;
                    m_value = SAT ? MAXV : (m_value + s - (MAXV + 1));
                end else begin
                    m_value = m_value + s;
                end
            end else begin
                if (m_value < s) begin
                    m_un    = 1'b1;
                    m_value = SAT ? 0 : (m_value + (MAXV + 1) - s);
                end else begin
                    m_value = m_value - s;
                end
            end
            if (m_ov || m_un) begin
                m_events++;
                if (m_wc < 65535) m_wc++;
            end
        end
    endtask

    // Apply one cycle of stimulus; optionally queue and check the result.
    task automatic cyc(input string tag, input bit r, input bit ld, input int lv,
                       input bit e, input bit dn, input int st, input bit do_chk);
        exp_t ex;
        exp_t got;
        reset      = r;
        load       = ld;
        load_value = WIDTH'(lv);
        en         = e;
        inst       = dn;
        step       = STEP_WIDTH'(st);
        model_step(r, ld, lv, e, dn, st);
        if (do_chk) begin
            ex.value = m_value;
            ex.ov    = m_ov;
            ex.un    = m_un;
            ex.wc    = m_wc;
            sb.push_back(ex);
        end
        @(posedge clock);
        #1;
        if (do_chk) begin
            got = sb.pop_front();
            n_txn++;
            $display("txn %0d %s: value=%0d ovf=%0b unf=%0b at_max=%0b at_zero=%0b wrap_count=%0d",
                     n_txn, tag, value, overflow, underflow, at_max, at_zero, wrap_count);
            chk({tag, ".value"},      int'(value),      got.value);
            chk({tag, ".overflow"},   int'(overflow),   int'(got.ov));
            chk({tag, ".underflow"},  int'(underflow),  int'(got.un));
            chk({tag, ".wrap_count"}, int'(wrap_count), got.wc);
            chk({tag, ".at_max"},     int'(at_max),     int'(got.value == MAXV));
            chk({tag, ".at_zero"},    int'(at_zero),    int'(got.value == 0));
        end
    endtask

    initial begin
        int guard;
        @(posedge clock);
        #1;

        // Reset state
        cyc("reset", 1, 0, 0, 0, 0, 0, 1);

        // Up-count by 1 through the top of the range
        for (int i = 0; i < 12; i++) cyc("up1", 0, 0, 0, 1, 0, 1, 1);
        chk("up1.final_wrap_count", int'(wrap_count), 1);
        chk("up1.final_value", int'(value), 2);

        // Load 2, then down by 3 underflows
        cyc("load2", 0, 1, 2, 0, 0, 0, 1);
        cyc("down3", 0, 0, 0, 1, 1, 3, 1);
        chk("down3.value_abs", int'(value), SAT ? 0 : 9);

        // Load above range clamps; load beats en in the same cycle
        cyc("load200", 0, 1, 200, 0, 0, 0, 1);
        cyc("load_vs_en", 0, 1, 3, 1, 0, 5, 1);

        // Oversized step is clamped to MAX_VALUE
        cyc("load7", 0, 1, 7, 0, 0, 0, 1);
        cyc("up15", 0, 0, 0, 1, 0, 15, 1);
        chk("up15.value_abs", int'(value), SAT ? 9 : 6);

        // Zero step and idle cycles hold everything
        for (int i = 0; i < 5; i++) cyc("step0", 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc("idle", 0, 0, 5, 0, 1, 7, 1);

        // Direction reversal every cycle, no dead cycle
        cyc("load4", 0, 1, 4, 0, 0, 0, 1);
        cyc("rev_up2", 0, 0, 0, 1, 0, 2, 1);
        cyc("rev_dn5", 0, 0, 0, 1, 1, 5, 1);
        cyc("rev_up4", 0, 0, 0, 1, 0, 4, 1);
        cyc("rev_dn7", 0, 0, 0, 1, 1, 7, 1);
        cyc("rev_dn1", 0, 0, 0, 1, 1, 1, 1);

        // Drive more than 65535 wrap events, then confirm saturation
        cyc("load7b", 0, 1, 7, 0, 0, 0, 1);
        guard = 0;
        while (m_events < 65540 && guard < 80000) begin
            cyc("bulk", 0, 0, 0, 1, 0, 9, 0);
            guard++;
        end
        chk("bulk.event_budget", int'(m_events >= 65540), 1);
        cyc("sat_up9", 0, 0, 0, 1, 0, 9, 1);
        cyc("sat_up9b", 0, 0, 0, 1, 0, 9, 1);
        chk("sat.wrap_count_ffff", int'(wrap_count), 16'hFFFF);

        // Reset overrides concurrent load and enable
        cyc("reset_mid", 1, 1, 5, 1, 0, 3, 1);
        chk("reset_mid.at_zero", int'(at_zero), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 32: counter width in bits, range 2..32.
REQ-002 Parameter MAX_VALUE, default 2**WIDTH-1: top count; counter range is 0..MAX_VALUE; 1 <= MAX_VALUE <= 2**WIDTH-1.
REQ-003 Parameter STEP_WIDTH, default 8: width of step input, range 1..WIDTH.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; one step applied per cycle while high.
REQ-007 inst  input  1  direction: 0 = count up, 1 = count down.
REQ-008 step  input  STEP_WIDTH  increment/decrement magnitude, unsigned.
REQ-009 load  input  1  synchronous parallel load strobe.
REQ-010 load_value  input  WIDTH  value written on load.
REQ-011 value  output  WIDTH  registered count.
REQ-012 overflow  output  1  registered one-cycle pulse: up-count crossed MAX_VALUE.
REQ-013 underflow  output  1  registered one-cycle pulse: down-count crossed 0.
REQ-014 at_max  output  1  combinational, value == MAX_VALUE.
REQ-015 at_zero  output  1  combinational, value == 0.
REQ-016 wrap_count  output  16  registered count of overflow plus underflow events.

Function
REQ-017 Per-edge priority SHALL be reset > load > en; with none active, all registers hold and overflow/underflow SHALL be 0.
REQ-018 Load: value <= min(load_value, MAX_VALUE); overflow = underflow = 0; wrap_count unchanged; en and inst ignored that cycle.
REQ-019 Effective step s = min(step, MAX_VALUE); en=1 with s=0 SHALL leave value unchanged with no flags.
REQ-020 Arithmetic SHALL be carried out at WIDTH+1 bits minimum; no intermediate truncation before range checks.
REQ-021 Up (inst=0, en=1): if value+s <= MAX_VALUE then value <= value+s, else overflow event.
REQ-022 Down (inst=1, en=1): if value >= s then value <= value-s, else underflow event.
REQ-023 Wrap mode (macro absent): overflow gives value <= value+s-(MAX_VALUE+1); underflow gives value <= value+(MAX_VALUE+1)-s.
REQ-024 On any overflow/underflow event the matching flag SHALL be 1 in the cycle the new value appears (latency 1 clock, same as value), 0 otherwise.
REQ-025 wrap_count SHALL increment by 1 per overflow or underflow event and saturate at 16'hFFFF; cleared only by reset.
REQ-026 inst changes SHALL take effect on the next enabled edge; no dead cycle on direction reversal.

Reset
REQ-027 reset=1 at an edge: value=0, overflow=0, underflow=0, wrap_count=0; at_zero=1, at_max=0 the following cycle; reset overrides load/en mid-operation.

Configuration
REQ-028 Macro UPDOWN_COUNTER_SATURATE_EN: when defined, an overflow event SHALL set value <= MAX_VALUE and an underflow event SHALL set value <= 0 (clamp), still pulsing overflow/underflow and counting in wrap_count; when undefined, wrap behaviour of REQ-023 applies. Port list identical in both builds.

Verification (WIDTH=8, MAX_VALUE=9, STEP_WIDTH=4)
REQ-029 reset 1 cycle, then en=1, inst=0, step=1 for 12 cycles -> value 1..9,0,1,2; overflow pulses exactly once, coincident with value=0; wrap_count=1.
REQ-030 load=1, load_value=2, then en=1, inst=1, step=3 -> value 2, then 9 with underflow=1 (wrap build) or 0 with underflow=1 (saturate build); wrap_count increments.
REQ-031 load=1, load_value=200 -> value=9, at_max=1, no flags; same cycle load=1 and en=1 -> load wins.
REQ-032 value=7, en=1, inst=0, step=15 -> s clamped to 9; wrap build value=6, overflow=1; saturate build value=9, overflow=1.
REQ-033 Force 65540 wrap events -> wrap_count holds 16'hFFFF; assert reset concurrently with load and en -> all outputs return to reset values next cycle.
REQ-034 en=1, step=0 for 5 cycles and en=0 for 5 cycles -> value constant, no flags, wrap_count constant.
